tff_mod_counter: RTL and testbench

//   Parametrised successor to the single T flip-flop: a WIDTH-bit bank of T flip-flops.
//   The bank runs in one of four modes:
//     - per-bit toggle,
//     - modulo-N up count,
//     - modulo-N down count,
//     - parallel load.
//   It also provides a terminal-count pulse and a saturating wrap counter.

---
 rtl/tff_mod_counter.sv | 97 +++++++++
 tb/tb_tff_mod_counter.sv | 117 +++++++++++
 2 files changed

// File: rtl/tff_mod_counter.sv
// WIDTH-bit bank of T flip-flops with toggle, modulo up/down count and clamped load modes.
// Also provides a registered terminal-count pulse and a saturating wrap counter.
module tff_mod_counter #(
   parameter int WIDTH  = 4,
   parameter int MODULO = 10,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              En,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  T,
   input  logic [WIDTH-1:0]  D,
   output logic [WIDTH-1:0]  Q,
   output logic              tc,
   output logic [WRAP_W-1:0] wrap_cnt
);

   typedef enum logic [1:0] {
      MODE_TOGGLE = 2'b00,
      MODE_UP     = 2'b01,
      MODE_DOWN   = 2'b10,
      MODE_LOAD   = 2'b11
   } mode_e;

   // Held one bit wider so MODULO == 2**WIDTH does not overflow the compare.
   localparam logic [WIDTH:0]   MOD_MAX_W = (WIDTH+1)'(MODULO - 1);
   localparam logic [WIDTH-1:0] MOD_MAX   = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0]  q_q,    q_d;
   logic              tc_q,   tc_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   mode_e             mode_s;

   function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
      return (&v) ? v : v + WRAP_W'(1);
   endfunction

   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      return ({1'b0, v} > MOD_MAX_W) ? MOD_MAX : v;
   endfunction

   function automatic logic at_top(input logic [WIDTH-1:0] v);
      return {1'b0, v} >= MOD_MAX_W;
   endfunction

   assign mode_s = mode_e'(mode);

   always_comb begin
      q_d    = q_q;
      tc_d   = 1'b0;
      wrap_d = wrap_q;
      if (En) begin
         unique case (mode_s)
            MODE_TOGGLE: q_d = q_q ^ T;
            MODE_UP: begin
               if (at_top(q_q)) begin
                  q_d    = '0;
                  tc_d   = 1'b1;
                  wrap_d = sat_inc(wrap_q);
               end else begin
                  q_d = q_q + WIDTH'(1);
               end
            end
            MODE_DOWN: begin
               // Out-of-range values left by TOGGLE re-enter at the top of the range.
               if (q_q == '0 || {1'b0, q_q} > MOD_MAX_W) begin
                  q_d    = MOD_MAX;
                  tc_d   = 1'b1;
                  wrap_d = sat_inc(wrap_q);
               end else begin
                  q_d = q_q - WIDTH'(1);
               end
            end
            MODE_LOAD: q_d = clamp_load(D);
            default:   q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q    <= '0;
         tc_q   <= 1'b0;
         wrap_q <= '0;
      end else begin
         q_q    <= q_d;
         tc_q   <= tc_d;
         wrap_q <= wrap_d;
      end
   end

   assign Q        = q_q;
   assign tc       = tc_q;
   assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed-vector bench for tff_mod_counter at WIDTH=4, MODULO=10, WRAP_W=2.
module tb_tff_mod_counter;

   localparam int WIDTH  = 4;
   localparam int MODULO = 10;
   localparam int WRAP_W = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              En;
   logic [1:0]        mode;
   logic [WIDTH-1:0]  T;
   logic [WIDTH-1:0]  D;
   logic [WIDTH-1:0]  Q;
   logic              tc;
   logic [WRAP_W-1:0] wrap_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   tff_mod_counter #(.WIDTH(WIDTH), .MODULO(MODULO), .WRAP_W(WRAP_W)) dut (
      .clk(clk), .reset(reset), .En(En), .mode(mode), .T(T), .D(D),
      .Q(Q), .tc(tc), .wrap_cnt(wrap_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step_check(input string tag, input int eq, input int etc, input int ew);
      @(posedge clk);
      #1;
      check({tag, ".Q"}, 32'(Q), 32'(eq));
      check({tag, ".tc"}, 32'(tc), 32'(etc));
      check({tag, ".wrap"}, 32'(wrap_cnt), 32'(ew));
   endtask

   initial begin
      int eq;
      int ew;
      reset = 1'b1; En = 1'b1; mode = 2'b01; T = '0; D = '0;

      // 1: reset dominates an enabled UP count
      for (int i = 0; i < 3; i++) step_check("rst", 0, 0, 0);

      // 2: legacy TFF toggle, then multi-bit toggle, then hold
      reset = 1'b0; mode = 2'b00; T = 4'b0001;
      step_check("tog1a", 1, 0, 0);
      step_check("tog1b", 0, 0, 0);
      step_check("tog1c", 1, 0, 0);
      step_check("tog1d", 0, 0, 0);
      T = 4'b1010;
      step_check("togAa", 10, 0, 0);
      step_check("togAb", 0, 0, 0);
      step_check("togAc", 10, 0, 0);
      En = 1'b0;
      step_check("hold1", 10, 0, 0);
      step_check("hold2", 10, 0, 0);

      // 3: modulo-10 up count across one wrap
      reset = 1'b1; En = 1'b1;
      step_check("rst3", 0, 0, 0);
      reset = 1'b0; mode = 2'b01;
      for (int i = 1; i <= 12; i++) begin
         eq = i % 10;
         step_check("up", eq, (eq == 0) ? 1 : 0, (i >= 10) ? 1 : 0);
      end

      // 4: down count from 0, then from an out-of-range toggled value
      reset = 1'b1;
      step_check("rst4", 0, 0, 0);
      reset = 1'b0; mode = 2'b10;
      step_check("dn0", 9, 1, 1);
      step_check("dn1", 8, 0, 1);
      step_check("dn2", 7, 0, 1);
      mode = 2'b00; T = 4'b1000;
      step_check("tog15", 15, 0, 1);
      mode = 2'b10;
      step_check("dn15", 9, 1, 2);

      // 5: clamped load and disabled load
      mode = 2'b11; D = 4'd13;
      step_check("ld13", 9, 0, 2);
      D = 4'd5;
      step_check("ld5", 5, 0, 2);
      En = 1'b0; D = 4'd3;
      step_check("ldoff", 5, 0, 2);
      En = 1'b1; D = 4'd15;
      step_check("ld15", 9, 0, 2);
      mode = 2'b01;
      step_check("upwrap", 0, 1, 3);
      En = 1'b0;
      step_check("tcoff", 0, 0, 3);

      // 6: reset mid-count, then saturate wrap_cnt over five wraps
      En = 1'b1;
      for (int i = 1; i <= 7; i++) step_check("to7", i, 0, 3);
      reset = 1'b1;
      step_check("rstmid", 0, 0, 0);
      reset = 1'b0;
      for (int i = 1; i <= 50; i++) begin
         eq = i % 10;
         ew = (i / 10 > 3) ? 3 : i / 10;
         step_check("sat", eq, (eq == 0) ? 1 : 0, ew);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
